// File: rtl/pcs_10g_frame_gen.sv
// Test-frame generator feeding pcs_tx: emits idle / start / data / term blocks with a
// counting payload pattern, one registered block per consumed (ready_i=1) cycle.
module pcs_10g_frame_gen #(
    parameter int DATA_W      = 64,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LANE0_CNT_N = 2
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   en_i,
    input  logic [10:0]            len_i,
    input  logic [3:0]             ipg_i,
    input  logic                   err_inj_i,
    input  logic                   ready_i,
    output logic                   ctrl_v_o,
    output logic                   idle_v_o,
    output logic [LANE0_CNT_N-1:0] start_v_o,
    output logic                   term_v_o,
    output logic                   err_v_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [KEEP_W-1:0]      keep_o,
    output logic [15:0]            frame_cnt_o
);

    localparam logic [2:0] IDLE_S  = 3'd0;
    localparam logic [2:0] START_S = 3'd1;
    localparam logic [2:0] DATA_S  = 3'd2;
    localparam logic [2:0] TERM_S  = 3'd3;
    localparam logic [2:0] IPG_S   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [10:0]            rem_q, rem_d;
    logic [7:0]             pat_q, pat_d;
    logic [3:0]             ipg_cfg_q, ipg_cfg_d;
    logic [3:0]             ipg_cnt_q, ipg_cnt_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   err_pend_q, err_pend_d;
    logic                   ctrl_v_q, ctrl_v_d;
    logic                   idle_v_q, idle_v_d;
    logic [LANE0_CNT_N-1:0] start_v_q, start_v_d;
    logic                   term_v_q, term_v_d;
    logic                   err_v_q, err_v_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [KEEP_W-1:0]      keep_q, keep_d;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pat_d       = pat_q;
        ipg_cfg_d   = ipg_cfg_q;
        ipg_cnt_d   = ipg_cnt_q;
        frame_cnt_d = frame_cnt_q;
        // A pulse is remembered even across stalls so it is never lost.
        err_pend_d  = err_pend_q | err_inj_i;
        ctrl_v_d    = ctrl_v_q;
        idle_v_d    = idle_v_q;
        start_v_d   = start_v_q;
        term_v_d    = term_v_q;
        err_v_d     = err_v_q;
        data_d      = data_q;
        keep_d      = keep_q;

        if (ready_i) begin
            case (state_q)
                IDLE_S:  state_d = en_i ? START_S : IDLE_S;
                START_S: state_d = DATA_S;
                DATA_S:  state_d = (rem_q < 11'(KEEP_W)) ? TERM_S : DATA_S;
                TERM_S: begin
                    state_d     = IPG_S;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    ipg_cnt_d   = (ipg_cfg_q == 4'd0) ? 4'd0 : ipg_cfg_q - 4'd1;
                end
                IPG_S: begin
                    if (ipg_cnt_q != 4'd0) begin
                        ipg_cnt_d = ipg_cnt_q - 4'd1;
                    end else begin
                        state_d = en_i ? START_S : IDLE_S;
                    end
                end
                default: state_d = IDLE_S;
            endcase

            ctrl_v_d  = 1'b1;
            idle_v_d  = 1'b0;
            start_v_d = '0;
            term_v_d  = 1'b0;
            err_v_d   = 1'b0;
            keep_d    = '0;
            data_d    = '0;

            // rem_q counts payload bytes still to be sent after the presented block.
            case (state_d)
                START_S: begin
                    start_v_d[0] = 1'b1;
                    keep_d       = '1;
                    keep_d[0]    = 1'b0;
                    for (int i = 1; i < KEEP_W - 1; i++) begin
                        data_d[i*8 +: 8] = 8'h55;
                    end
                    data_d[DATA_W-8 +: 8] = 8'hD5;
                    rem_d     = len_i;
                    ipg_cfg_d = ipg_i;
                    pat_d     = frame_cnt_q[7:0];
                end
                DATA_S: begin
                    ctrl_v_d = 1'b0;
                    keep_d   = '1;
                    for (int i = 0; i < KEEP_W; i++) begin
                        data_d[i*8 +: 8] = pat_q + 8'(i);
                    end
                    rem_d      = rem_q - 11'(KEEP_W);
                    pat_d      = pat_q + 8'(KEEP_W);
                    err_v_d    = err_pend_d;
                    err_pend_d = 1'b0;
                end
                TERM_S: begin
                    term_v_d = 1'b1;
                    for (int i = 0; i < KEEP_W; i++) begin
                        if (11'(i) < rem_q) begin
                            keep_d[i]        = 1'b1;
                            data_d[i*8 +: 8] = pat_q + 8'(i);
                        end
                    end
                end
                default: idle_v_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE_S;
            rem_q       <= '0;
            pat_q       <= '0;
            ipg_cfg_q   <= '0;
            ipg_cnt_q   <= '0;
            frame_cnt_q <= '0;
            err_pend_q  <= 1'b0;
            ctrl_v_q    <= 1'b1;
            idle_v_q    <= 1'b1;
            start_v_q   <= '0;
            term_v_q    <= 1'b0;
            err_v_q     <= 1'b0;
            data_q      <= '0;
            keep_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            pat_q       <= pat_d;
            ipg_cfg_q   <= ipg_cfg_d;
            ipg_cnt_q   <= ipg_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_pend_q  <= err_pend_d;
            ctrl_v_q    <= ctrl_v_d;
            idle_v_q    <= idle_v_d;
            start_v_q   <= start_v_d;
            term_v_q    <= term_v_d;
            err_v_q     <= err_v_d;
            data_q      <= data_d;
            keep_q      <= keep_d;
        end
    end

    assign ctrl_v_o    = ctrl_v_q;
    assign idle_v_o    = idle_v_q;
    assign start_v_o   = start_v_q;
    assign term_v_o    = term_v_q;
    assign err_v_o     = err_v_q;
    assign data_o      = data_q;
    assign keep_o      = keep_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: doc/pcs_10g_frame_gen.md
PCS_10G_FRAME_GEN -- requirements
Module: pcs_10g_frame_gen

Interface
REQ-001 Parameter DATA_W, 64, data path width in bits.
REQ-002 Parameter KEEP_W, DATA_W/8, byte-enable width.
REQ-003 Parameter LANE0_CNT_N, 2, start-position flags: bit0 is lane 0, bit1 is lane 4.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port nreset, input, 1: reset is asynchronous and active-low.
REQ-006 Port en_i, input, 1: generation enable, sampled only in IDLE_S.
REQ-007 Port len_i, input, 11: payload byte count per frame, legal range 64..1518, sampled at frame start.
REQ-008 Port ipg_i, input, 4: idle blocks between frames, sampled at frame start; 0 is treated as 1.
REQ-009 Port err_inj_i, input, 1: single-cycle pulse; the next DATA block emitted is flagged as an error.
REQ-010 Port ready_i, input, 1: pcs_tx ready_o; a block is consumed only on a cycle with ready_i=1.
REQ-011 Outputs ctrl_v_o (1), idle_v_o (1), start_v_o (LANE0_CNT_N), term_v_o (1) and err_v_o (1) drive the same-named pcs_tx inputs.
REQ-012 Outputs data_o (DATA_W) and keep_o (KEEP_W) carry the block payload and byte-valid mask; byte 0 is data_o[7:0].
REQ-013 Output frame_cnt_o, 16: count of completed frames, wraps at 0xFFFF to 0.

Function
REQ-014 All block outputs shall be registered; a new block is presented the cycle after the previous block was consumed (ready_i=1).
REQ-015 While ready_i=0, every block output shall hold its value and no state, counter or sampled config shall change.
REQ-016 States: IDLE_S, START_S, DATA_S, TERM_S, IPG_S.
REQ-017 IDLE_S emits an idle block: ctrl_v=1, idle_v=1, keep=0, data=0. It moves to START_S when en_i=1 and the block is consumed.
REQ-018 START_S emits a lane-0 start block: ctrl_v=1, start_v=2'b01, keep=8'hFE, data bytes 1..6=0x55, byte 7=0xD5, byte 0=0x00. len_i and ipg_i are latched here.
REQ-019 DATA_S emits full blocks: ctrl_v=0, keep=8'hFF. Payload byte n of the frame equals (n + frame_cnt_o[7:0]) mod 256, with n starting at 0.
REQ-020 The remaining-byte counter decrements by 8 per consumed DATA block. DATA_S exits to TERM_S when the remainder is less than 8.
REQ-021 TERM_S emits ctrl_v=1, term_v=1, keep = (1<<rem)-1, with rem = len mod 8. Valid bytes continue the payload pattern; invalid bytes are 0. rem=0 gives keep=0.
REQ-022 On consumption of the TERM block, frame_cnt_o increments and the FSM moves to IPG_S.
REQ-023 IPG_S emits max(ipg,1) idle blocks, then moves to START_S if en_i=1, otherwise to IDLE_S.
REQ-024 err_inj_i sets a sticky pending flag. The next consumed DATA_S block has err_v_o=1 and clears the flag. A pulse that arrives during TERM_S or IPG_S applies to the next frame.
REQ-025 Deasserting en_i mid-frame shall not truncate the frame; the frame completes through TERM_S and IPG_S.
REQ-026 err_v_o=0 and start_v_o=0 in every state except where REQ-018 and REQ-024 set them.

Reset
REQ-027 Asserting nreset low immediately forces: state IDLE_S, ctrl_v_o=1, idle_v_o=1, all other flags 0, data_o=0, keep_o=0, frame_cnt_o=0, err-pending flag cleared.
REQ-028 A reset asserted mid-frame abandons the frame with no TERM block, and frame_cnt_o is not incremented.
REQ-029 The first non-idle block after reset release shall appear no earlier than 2 cycles after en_i=1 is seen with ready_i=1.

Verification
REQ-030 en_i=1, len=64, ipg=3, ready_i=1 continuously: expect START; 8 DATA blocks with bytes 0x00..0x3F; TERM with keep=0x00; 3 idle blocks; frame_cnt_o=1.
REQ-031 len=67, frame_cnt_o=5: expect 8 DATA blocks starting at byte 0x05, then TERM keep=0x07 with bytes 0x45,0x46,0x47.
REQ-032 ready_i=0 for 1 cycle out of every 33 across a 1518-byte frame: expect outputs held during stalls, exactly 189 DATA blocks, TERM keep=0x3F.
REQ-033 err_inj_i pulsed during START_S: expect err_v_o=1 on the first DATA block only; a pulse during IPG_S flags the first DATA block of the next frame.
REQ-034 nreset low during DATA_S: expect idle outputs immediately and frame_cnt_o=0; after release with en_i=1, a clean START followed by a full frame.
REQ-035 en_i dropped mid-frame with ipg=0: expect the frame completes, exactly 1 idle block in IPG_S, then IDLE_S idling indefinitely.
